// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the multiply/divide sequencer.
// Holds the op encoding, the sequencer state enum and the default width.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shift-add multiplier / restoring divider working registers.
// Ports: clk, reset (sync, high); load/step/op controls; a, b operands;
// res_hi/res_lo/res_dbz = result of the register state after this cycle.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             res_dbz
);

  logic               op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  // Remainder is always < b after a restore, so its top bit is
  // always zero between steps; only the shifted copy needs W+1 bits.
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH+1:0]   diff;

  always_comb begin
    op_d = op_q;
    a_d  = a_q;
    b_d  = b_q;
    p_d  = p_q;
    r_d  = r_q;
    q_d  = q_q;
    sum  = '0;
    r_sh = '0;
    diff = '0;
    if (load) begin
      op_d = op;
      a_d  = a;
      b_d  = b;
      p_d  = {{WIDTH{1'b0}}, a};
      r_d  = '0;
      q_d  = a;
    end else if (step) begin
      if (op_q == OP_MUL) begin
        // Carry out of the upper half is shifted back in.
        sum = {1'b0, p_q[2*WIDTH-1:WIDTH]}
            + (p_q[0] ? {1'b0, b_q} : '0);
        p_d = {sum, p_q[WIDTH-1:1]};
      end else begin
        r_sh = {r_q, q_q[WIDTH-1]};
        diff = {1'b0, r_sh} - {2'b00, b_q};
        q_d  = {q_q[WIDTH-2:0], ~diff[WIDTH+1]};
        if (!diff[WIDTH+1]) begin
          r_d = diff[WIDTH-1:0];
        end else begin
          r_d = r_sh[WIDTH-1:0];
        end
      end
    end
  end

  // Result is taken from the next-state values so the controller
  // can capture it on the same edge as the final step.
  always_comb begin
    res_hi  = p_d[2*WIDTH-1:WIDTH];
    res_lo  = p_d[WIDTH-1:0];
    res_dbz = 1'b0;
    if (op_q == OP_DIV) begin
      if (b_q == '0) begin
        res_hi  = a_q;
        res_lo  = '1;
        res_dbz = 1'b1;
      end else begin
        res_hi  = r_d;
        res_lo  = q_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= OP_MUL;
      a_q  <= '0;
      b_q  <= '0;
      p_q  <= '0;
      r_q  <= '0;
      q_q  <= '0;
    end else begin
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
      p_q  <= p_d;
      r_q  <= r_d;
      q_q  <= q_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MUL/DIV sequencer owning the HI/LO registers.
// Ports: clk, reset (sync, high); start/op/a/b request; busy, done,
// hi, lo, div_by_zero results (all registered).
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  muldiv_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic             load;
  logic             step;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             res_dbz;

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .res_dbz(res_dbz)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = CW'(WIDTH - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == '0) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          dbz_d   = res_dbz;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = CW'(WIDTH - 1);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed plus random checks of muldiv_ctrl against
// a plain-arithmetic model of MUL/DIV results and cycle timing.
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] hi;
  logic [15:0] lo;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] e_hi;
  logic [15:0] e_lo;
  logic        e_dbz;

  muldiv_ctrl #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic o,
                       input logic [15:0] x,
                       input logic [15:0] y,
                       output logic [15:0] h,
                       output logic [15:0] l,
                       output logic z);
    logic [31:0] pr;
    pr = 32'(x) * 32'(y);
    if (o == 1'b0) begin
      h = pr[31:16];
      l = pr[15:0];
      z = 1'b0;
    end else if (y == 16'd0) begin
      h = x;
      l = 16'hFFFF;
      z = 1'b1;
    end else begin
      h = x % y;
      l = x / y;
      z = 1'b0;
    end
  endtask

  // Called right after a negedge; leaves us at the negedge of cycle 1.
  task automatic start_op(input logic o,
                          input logic [15:0] x,
                          input logic [15:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at negedge of cycle 1 of an accepted op.
  task automatic track(input logic o,
                       input logic [15:0] x,
                       input logic [15:0] y,
                       input int poke,
                       input bit chain,
                       input logic no,
                       input logic [15:0] nx,
                       input logic [15:0] ny);
    logic [15:0] nh, nl;
    logic        nz;
    model(o, x, y, nh, nl, nz);
    for (int c = 1; c <= 16; c++) begin
      check("busy_run", {31'd0, busy}, 32'd1);
      check("done_run", {31'd0, done}, 32'd0);
      check("hold_hilo", {hi, lo}, {e_hi, e_lo});
      check("hold_dbz", {31'd0, div_by_zero}, {31'd0, e_dbz});
      if (c == poke) begin
        start = 1'b1;
        op    = ~o;
        a     = 16'($urandom);
        b     = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("result", {hi, lo}, {nh, nl});
    check("dbz", {31'd0, div_by_zero}, {31'd0, nz});
    e_hi  = nh;
    e_lo  = nl;
    e_dbz = nz;
    if (chain) begin
      start_op(no, nx, ny);
      check("b2b_busy", {31'd0, busy}, 32'd1);
    end else begin
      @(negedge clk);
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_hold", {hi, lo}, {e_hi, e_lo});
    end
  endtask

  initial begin
    logic        co, no;
    logic [15:0] cx, cy, nx, ny;
    bit          ch;

    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    e_hi  = '0;
    e_lo  = '0;
    e_dbz = 1'b0;
    repeat (3) @(negedge clk);
    // Start alongside reset must lose to reset.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hilo", {hi, lo}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    check("rst_idle", {31'd0, busy}, 32'd0);

    start_op(1'b0, 16'd7, 16'd9);
    track(1'b0, 16'd7, 16'd9, 0, 0, 1'b0, 16'd0, 16'd0);
    check("mul7x9", {hi, lo}, 32'h0000_003F);

    start_op(1'b0, 16'hFFFF, 16'hFFFF);
    track(1'b0, 16'hFFFF, 16'hFFFF, 0, 0, 1'b0, 16'd0, 16'd0);
    check("mul_max", {hi, lo}, 32'hFFFE_0001);

    start_op(1'b1, 16'd100, 16'd7);
    track(1'b1, 16'd100, 16'd7, 0, 0, 1'b0, 16'd0, 16'd0);
    check("div100_7", {hi, lo}, {16'd2, 16'd14});

    start_op(1'b1, 16'd3, 16'h8000);
    track(1'b1, 16'd3, 16'h8000, 0, 0, 1'b0, 16'd0, 16'd0);
    check("div3_8000", {hi, lo}, {16'd3, 16'd0});

    start_op(1'b1, 16'd5, 16'd0);
    track(1'b1, 16'd5, 16'd0, 0, 0, 1'b0, 16'd0, 16'd0);
    check("div0_res", {hi, lo}, {16'd5, 16'hFFFF});
    check("div0_flag", {31'd0, div_by_zero}, 32'd1);

    start_op(1'b0, 16'd2, 16'd3);
    track(1'b0, 16'd2, 16'd3, 0, 0, 1'b0, 16'd0, 16'd0);
    check("mul_clr", {15'd0, div_by_zero, lo}, 32'd6);

    start_op(1'b0, 16'h1234, 16'h00AB);
    track(1'b0, 16'h1234, 16'h00AB, 5, 1, 1'b1, 16'hBEEF, 16'h0013);
    track(1'b1, 16'hBEEF, 16'h0013, 0, 0, 1'b0, 16'd0, 16'd0);

    co = 1'($urandom_range(0, 1));
    cx = 16'($urandom);
    cy = 16'($urandom);
    start_op(co, cx, cy);
    for (int i = 0; i < 14; i++) begin
      no = 1'($urandom_range(0, 1));
      nx = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       ny = 16'd0;
        1:       ny = 16'($urandom_range(1, 15));
        default: ny = 16'($urandom);
      endcase
      ch = 1'($urandom_range(0, 1));
      track(co, cx, cy, 0, ch, no, nx, ny);
      if (!ch) start_op(no, nx, ny);
      co = no;
      cx = nx;
      cy = ny;
    end
    track(co, cx, cy, 0, 0, 1'b0, 16'd0, 16'd0);

    start_op(1'b1, 16'd1000, 16'd7);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hilo", {hi, lo}, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    for (int c = 0; c < 20; c++) begin
      check("abort_nodone", {31'd0, done}, 32'd0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
